// File: rtl/banco_de_registradores_param_if.sv
// banco_de_registradores_param_if: read/write/clear bus of the parametrised register bank
interface banco_de_registradores_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   Read_1;
    logic [ADDR_W-1:0]   Read_2;
    logic [ADDR_W-1:0]   Address_to_write;
    logic [DATA_W-1:0]   Data_to_write;
    logic [DATA_W/8-1:0] Byte_enable;
    logic                Signal_write;
    logic                Signal_clear;
    logic [DATA_W-1:0]   Out_1;
    logic [DATA_W-1:0]   Out_2;
    logic                Busy;
    logic                Write_drop;

    modport master (
        output Read_1, Read_2, Address_to_write, Data_to_write, Byte_enable, Signal_write, Signal_clear,
        input  Out_1, Out_2, Busy, Write_drop
    );

    modport slave (
        input  Read_1, Read_2, Address_to_write, Data_to_write, Byte_enable, Signal_write, Signal_clear,
        output Out_1, Out_2, Busy, Write_drop
    );
endinterface

// File: rtl/banco_de_registradores_param.sv
// banco_de_registradores_param: 2R/1W register bank with byte enables, forwarding and clear sweep
module banco_de_registradores_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int READ_MODE = 0,
    parameter int BYPASS    = 1
) (
    input logic Clock_in,
    input logic Signal_reset,
    banco_de_registradores_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic                busy, wr_acc, wr_eff;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   wr_mask, wr_merged, rd1_d, rd2_d;

    // FSM state, sweep counter and drop pulse registers
    always_ff @(posedge Clock_in or posedge Signal_reset) begin
        if (Signal_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Next state: clear starts a sweep from IDLE; the sweep ends after clearing the last entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = bus.Signal_clear ? SWEEP : IDLE;
            cnt_d   = '0;
        end else begin
            state_d = (cnt_q == ADDR_W'(DEPTH - 1)) ? IDLE : SWEEP;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Outputs of the FSM: write acceptance (clear wins over write) and drop detection
    always_comb begin
        busy   = (state_q == SWEEP);
        wr_acc = bus.Signal_write && !busy && !bus.Signal_clear;
        wr_eff = wr_acc && !(ZERO_REG != 0 && bus.Address_to_write == '0);
        drop_d = bus.Signal_write && !wr_acc;
    end

    // Byte-lane merge of the write data into the currently stored word
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < NB; i++) wr_mask[8*i +: 8] = {8{bus.Byte_enable[i]}};
        wr_merged = (mem_q[bus.Address_to_write] & ~wr_mask) | (bus.Data_to_write & wr_mask);
    end

    // Storage: sweep zeroes one entry per cycle, otherwise an accepted write updates its entry
    always_ff @(posedge Clock_in or posedge Signal_reset) begin
        if (Signal_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_eff) begin
            mem_q[bus.Address_to_write] <= wr_merged;
        end
    end

    // Read values: register 0 forced to zero, same-cycle write forwarded when enabled
    always_comb begin
        rd1_d = (ZERO_REG != 0 && bus.Read_1 == '0) ? '0 :
                (BYPASS != 0 && wr_acc && bus.Read_1 == bus.Address_to_write) ? wr_merged : mem_q[bus.Read_1];
        rd2_d = (ZERO_REG != 0 && bus.Read_2 == '0) ? '0 :
                (BYPASS != 0 && wr_acc && bus.Read_2 == bus.Address_to_write) ? wr_merged : mem_q[bus.Read_2];
    end

    if (READ_MODE != 0) begin : g_reg_read
        logic [DATA_W-1:0] out1_q, out2_q;
        // Registered read ports sample the (optionally forwarded) value at each edge
        always_ff @(posedge Clock_in or posedge Signal_reset) begin
            if (Signal_reset) begin
                out1_q <= '0;
                out2_q <= '0;
            end else begin
                out1_q <= rd1_d;
                out2_q <= rd2_d;
            end
        end
        assign bus.Out_1 = out1_q;
        assign bus.Out_2 = out2_q;
    end else begin : g_comb_read
        assign bus.Out_1 = rd1_d;
        assign bus.Out_2 = rd2_d;
    end

    assign bus.Busy       = busy;
    assign bus.Write_drop = drop_q;
endmodule
